// File: rtl/pwm_timebase_out.sv
// Period timebase and compare-based output stage of one PPWM channel.
// Produces the prescaled global counter, the per-period start pulse and the PWM pin.
module pwm_timebase_out #(
  parameter int COUNTER_WIDTH  = 10,
  parameter int PRESCALE_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable_i,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  input  logic [COUNTER_WIDTH-1:0]  period_i,
  input  logic                      invert_i,
  input  logic [COUNTER_WIDTH-1:0]  pwm_value_i,
  output logic                      start_o,
  output logic [COUNTER_WIDTH-1:0]  global_counter_o,
  output logic                      pwm_o
);

  typedef enum logic {
    StOff = 1'b0,
    StRun = 1'b1
  } state_e;

  localparam logic [PRESCALE_WIDTH-1:0] PRE_ONE = PRESCALE_WIDTH'(1);
  localparam logic [COUNTER_WIDTH-1:0]  CNT_ONE = COUNTER_WIDTH'(1);

  state_e                    state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] pre_q, pre_d;
  logic [COUNTER_WIDTH-1:0]  cnt_q, cnt_d;
  logic                      start_q, start_d;
  logic                      pwm_q, pwm_d;
  logic [COUNTER_WIDTH-1:0]  period_q;
  logic [PRESCALE_WIDTH-1:0] prescale_q;
  logic [COUNTER_WIDTH-1:0]  duty_q;
  logic                      latch_shadows;
  logic                      tick;
  logic                      at_top;

  assign tick   = (pre_q == prescale_q);
  assign at_top = (cnt_q == period_q);

  always_comb begin
    state_d       = state_q;
    pre_d         = pre_q;
    cnt_d         = cnt_q;
    start_d       = 1'b0;
    pwm_d         = invert_i;
    latch_shadows = 1'b0;
    unique case (state_q)
      StOff: begin
        cnt_d = '0;
        pre_d = '0;
        if (enable_i) begin
          state_d       = StRun;
          start_d       = 1'b1;
          latch_shadows = 1'b1;
        end
      end
      StRun: begin
        // Compare uses the counter value of this cycle, so the pin lags it by one clk.
        pwm_d = (cnt_q < duty_q) ^ invert_i;
        if (!enable_i) begin
          state_d = StOff;
          cnt_d   = '0;
          pre_d   = '0;
        end else if (!tick) begin
          pre_d = pre_q + PRE_ONE;
        end else if (!at_top) begin
          pre_d = '0;
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          pre_d         = '0;
          cnt_d         = '0;
          start_d       = 1'b1;
          latch_shadows = 1'b1;
        end
      end
      default: begin
        state_d = StOff;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StOff;
      pre_q   <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      pwm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      pwm_q   <= pwm_d;
    end
  end

  // Shadows only move at enable or at a period wrap, so mid-period writes wait a period.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period_q   <= '0;
      prescale_q <= '0;
      duty_q     <= '0;
    end else if (latch_shadows) begin
      period_q   <= period_i;
      prescale_q <= prescale_i;
      duty_q     <= pwm_value_i;
    end
  end

  assign start_o          = start_q;
  assign global_counter_o = cnt_q;
  assign pwm_o            = pwm_q;

endmodule

// File: tb/tb_pwm_timebase_out.sv
// Directed bench for pwm_timebase_out: elapsed-cycle model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_pwm_timebase_out;

  localparam int CW = 10;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [PW-1:0] prescale = '0;
  logic [CW-1:0] period = '0;
  logic          invert = 1'b0;
  logic [CW-1:0] pwm_value = '0;
  logic          start_o;
  logic [CW-1:0] cnt_o;
  logic          pwm_o;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  pwm_timebase_out #(.COUNTER_WIDTH(CW), .PRESCALE_WIDTH(PW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable_i         (enable),
    .prescale_i       (prescale),
    .period_i         (period),
    .invert_i         (invert),
    .pwm_value_i      (pwm_value),
    .start_o          (start_o),
    .global_counter_o (cnt_o),
    .pwm_o            (pwm_o)
  );

  always #5 clk = ~clk;

  // Model: cycles elapsed since the period began; counter = elapsed / (prescale+1).
  bit m_run = 1'b0;
  int m_el = 0;
  int m_p = 0;
  int m_s = 0;
  int m_d = 0;
  bit m_pwm = 1'b0;
  int m_cnt;
  bit m_start;

  always_comb begin
    m_cnt   = m_run ? (m_el / (m_s + 1)) : 0;
    m_start = m_run && (m_el == 0);
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_run <= 1'b0; m_el <= 0; m_p <= 0; m_s <= 0; m_d <= 0; m_pwm <= 1'b0;
    end else if (!m_run) begin
      m_pwm <= invert;
      if (enable) begin
        m_run <= 1'b1; m_el <= 0;
        m_p <= int'(period); m_s <= int'(prescale); m_d <= int'(pwm_value);
      end
    end else begin
      m_pwm <= (m_cnt < m_d) ^ invert;
      if (!enable) begin
        m_run <= 1'b0; m_el <= 0;
      end else if (m_el + 1 == (m_p + 1) * (m_s + 1)) begin
        m_el <= 0;
        m_p <= int'(period); m_s <= int'(prescale); m_d <= int'(pwm_value);
      end else begin
        m_el <= m_el + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_start", 32'(start_o), 32'(m_start));
      check("model_cnt", 32'(cnt_o), 32'(m_cnt));
      check("model_pwm", 32'(pwm_o), 32'(m_pwm));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic restart(input int p, input int s, input int v, input bit inv);
    enable = 1'b0;
    cyc();
    cyc();
    period = CW'(p); prescale = PW'(s); pwm_value = CW'(v); invert = inv;
    enable = 1'b1;
    cyc();
  endtask

  // Pin cycles 1..8 after enable reflect counter values 0..3 twice with period 3.
  task automatic run_extreme(input string name, input int v, input bit inv, input int exp_high);
    int high;
    high = 0;
    restart(3, 0, v, inv);
    for (int i = 0; i < 8; i++) begin
      cyc();
      high += int'(pwm_o);
    end
    check(name, 32'(high), 32'(exp_high));
  endtask

  initial begin
    int exp_cnt[8];
    int exp_pcnt[12];
    logic [7:0] st_seq, pw_seq;
    logic [11:0] st12, pw12;
    int high_a, high_b;

    cyc();
    chk_en = 1'b1;
    cyc();
    check("reset_cnt", 32'(cnt_o), 32'd0);
    check("reset_start", 32'(start_o), 32'd0);
    check("reset_pwm", 32'(pwm_o), 32'd0);

    // Basic: period 3, no prescale, duty 2.
    rst_n = 1'b1;
    period = 10'd3; prescale = 4'd0; pwm_value = 10'd2; invert = 1'b0; enable = 1'b1;
    cyc();
    exp_cnt = '{0, 1, 2, 3, 0, 1, 2, 3};
    for (int i = 0; i < 8; i++) begin
      check("basic_cnt", 32'(cnt_o), 32'(exp_cnt[i]));
      st_seq[i] = start_o;
      pw_seq[i] = pwm_o;
      cyc();
    end
    check("basic_start_seq", 32'(st_seq), 32'h11);
    check("basic_pwm_seq", 32'(pw_seq), 32'h66);

    // Prescale: period 2, divide by 2, duty 1.
    restart(2, 1, 1, 1'b0);
    exp_pcnt = '{0, 0, 1, 1, 2, 2, 0, 0, 1, 1, 2, 2};
    for (int i = 0; i < 12; i++) begin
      check("pre_cnt", 32'(cnt_o), 32'(exp_pcnt[i]));
      st12[i] = start_o;
      pw12[i] = pwm_o;
      cyc();
    end
    check("pre_start_seq", 32'(st12), 32'h041);
    check("pre_pwm_seq", 32'(pw12), 32'h186);

    // Shadow: duty 3 and period 5 written mid-period only apply after the wrap.
    restart(3, 0, 1, 1'b0);
    high_a = 0;
    high_b = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      if (i == 1) begin
        pwm_value = 10'd3;
        period = 10'd5;
      end
      if (i <= 4) high_a += int'(pwm_o);
      else high_b += int'(pwm_o);
      if (i == 4) check("shadow_wrap1_start", 32'(start_o), 32'd1);
      if (i == 8) check("shadow_long_cnt", 32'(cnt_o), 32'd4);
      if (i == 10) check("shadow_wrap2_start", 32'(start_o), 32'd1);
    end
    check("shadow_high_old", 32'(high_a), 32'd1);
    check("shadow_high_new", 32'(high_b), 32'd3);

    // Extremes and polarity.
    run_extreme("ext_duty0", 0, 1'b0, 0);
    run_extreme("ext_duty8", 8, 1'b0, 8);
    run_extreme("ext_duty0_inv", 0, 1'b1, 8);
    run_extreme("ext_duty8_inv", 8, 1'b1, 0);

    // Period 0, no prescale: start every cycle.
    restart(0, 0, 0, 1'b0);
    high_a = 0;
    for (int i = 0; i < 4; i++) begin
      high_a += int'(start_o);
      cyc();
    end
    check("p0_start_count", 32'(high_a), 32'd4);

    // Disable at counter 2, then re-enable.
    restart(3, 0, 3, 1'b0);
    cyc();
    cyc();
    check("dis_at_cnt", 32'(cnt_o), 32'd2);
    enable = 1'b0;
    cyc();
    check("dis_cnt", 32'(cnt_o), 32'd0);
    check("dis_start", 32'(start_o), 32'd0);
    check("dis_pwm_last", 32'(pwm_o), 32'd1);
    cyc();
    check("dis_pwm_idle", 32'(pwm_o), 32'd0);
    period = 10'd7; pwm_value = 10'd4;
    enable = 1'b1;
    cyc();
    check("reen_start", 32'(start_o), 32'd1);
    check("reen_cnt", 32'(cnt_o), 32'd0);

    // Reset mid-run at counter 5 with enable held.
    repeat (5) cyc();
    check("rst_at_cnt", 32'(cnt_o), 32'd5);
    rst_n = 1'b0;
    cyc();
    check("rst_cnt", 32'(cnt_o), 32'd0);
    check("rst_start", 32'(start_o), 32'd0);
    check("rst_pwm", 32'(pwm_o), 32'd0);
    rst_n = 1'b1;
    cyc();
    check("rst_rel_start", 32'(start_o), 32'd1);
    cyc();
    check("rst_rel_start_low", 32'(start_o), 32'd0);
    check("rst_rel_cnt", 32'(cnt_o), 32'd1);
    repeat (10) cyc();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
